// File: rtl/mem_responder.sv
// Multi-cycle word memory responder: fixed-latency read/write access with
// a one-cycle ready pulse and error flagging of malformed requests.
module mem_responder #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   word_q, word_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic                    err_lat_q, err_lat_d;
    logic [DATA_W-1:0]       read_data_q, read_data_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic                    req_err_c;
    logic                    eff_rd_c;
    logic                    eff_err_c;
    logic [DEPTH_LOG2-1:0]   eff_word_c;
    logic                    mem_we_c;

    // Request checks on live inputs; the "eff" view lets LATENCY=1 load
    // readData on the acceptance edge, before the latches are valid.
    always_comb begin
        req_err_c  = (adr[1:0] != 2'b00)
                   || ((adr >> (DEPTH_LOG2 + 2)) != '0)
                   || (memRead && memWrite);
        eff_rd_c   = (state_q == IDLE) ? memRead : rd_q;
        eff_err_c  = (state_q == IDLE) ? req_err_c : err_lat_q;
        eff_word_c = (state_q == IDLE) ? adr[DEPTH_LOG2+1:2] : word_q;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        err_lat_d   = err_lat_q;
        read_data_d = read_data_q;
        mem_we_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (memRead || memWrite) begin
                    word_d    = adr[DEPTH_LOG2+1:2];
                    wdata_d   = writeData;
                    rd_d      = memRead;
                    wr_d      = memWrite;
                    err_lat_d = req_err_c;
                    if (LATENCY <= 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d  = IDLE;
                mem_we_c = wr_q && !err_lat_q;
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == RESP) && eff_rd_c && !eff_err_c) begin
            read_data_d = mem_q[eff_word_c];
        end

        ready_d = (state_d == RESP);
        busy_d  = (state_d != IDLE);
        err_d   = (state_d == RESP) && eff_err_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            err_lat_q   <= 1'b0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            err_lat_q   <= err_lat_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Storage is never cleared; reset on the RESP edge drops the pending write
    always_ff @(posedge clk) begin
        if (rst && mem_we_c) begin
            mem_q[word_q] <= wdata_q;
        end
    end

    assign readData = read_data_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with LATENCY=2 and LATENCY=1 instances.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd2 = 1'b0, wr2 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] adr2 = '0, wd2 = '0, adr1 = '0, wd1 = '0;
    logic [31:0] rdata2, rdata1;
    logic        ready2, busy2, err2, ready1, busy1, err1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(8), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .memRead(rd2), .memWrite(wr2), .adr(adr2),
        .writeData(wd2), .readData(rdata2), .ready(ready2), .busy(busy2), .err(err2)
    );

    mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .memRead(rd1), .memWrite(wr1), .adr(adr1),
        .writeData(wd1), .readData(rdata1), .ready(ready1), .busy(busy1), .err(err1)
    );

    // One access on the selected instance (s=1 -> LATENCY=1). lat counts
    // edges from acceptance to the first sample with ready=1 (bounded at 20).
    task automatic access(input bit s, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic e, output logic [31:0] q);
        @(posedge clk); #1;
        if (s) begin rd1 = rd; wr1 = wr; adr1 = a; wd1 = d; end
        else   begin rd2 = rd; wr2 = wr; adr2 = a; wd2 = d; end
        @(posedge clk); #1;
        lat = 1;
        while (!(s ? ready1 : ready2) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = s ? err1 : err2;
        q = s ? rdata1 : rdata2;
        if (s) begin rd1 = 1'b0; wr1 = 1'b0; end
        else   begin rd2 = 1'b0; wr2 = 1'b0; end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready2 !== 1'b0 || busy2 !== 1'b0 || err2 !== 1'b0) begin errors++; $display("FAIL reset_flags2 got r=%b b=%b e=%b want 0 0 0", ready2, busy2, err2); end
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata2 got %h want 0", rdata2); end
        checks++; if (ready1 !== 1'b0 || busy1 !== 1'b0 || err1 !== 1'b0 || rdata1 !== 32'h0) begin errors++; $display("FAIL reset_dut1 got r=%b b=%b e=%b d=%h want zeros", ready1, busy1, err1, rdata1); end
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; logic e; logic [31:0] q;
        access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, e, q);
        checks++; if (lat !== 2 || e !== 1'b0) begin errors++; $display("FAIL wr10 got lat=%0d err=%b want 2 0", lat, e); end
        checks++; if (ready2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL wr10_after got r=%b b=%b want 0 0", ready2, busy2); end
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, e, q);
        checks++; if (lat !== 2 || e !== 1'b0 || q !== 32'hDEADBEEF) begin errors++; $display("FAIL rd10 got lat=%0d err=%b d=%h want 2 0 deadbeef", lat, e, q); end
    endtask

    task automatic test_misaligned();
        int lat; logic e; logic [31:0] q;
        access(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, lat, e, q);
        checks++; if (e !== 1'b1 || q !== 32'hDEADBEEF) begin errors++; $display("FAIL rd13 got err=%b d=%h want 1 deadbeef", e, q); end
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, e, q);
        checks++; if (e !== 1'b0 || q !== 32'hDEADBEEF) begin errors++; $display("FAIL rd10_again got err=%b d=%h want 0 deadbeef", e, q); end
    endtask

    task automatic test_conflict();
        int lat; logic e; logic [31:0] q;
        access(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFE0001, lat, e, q);
        access(1'b0, 1'b1, 1'b1, 32'h20, 32'h00001234, lat, e, q);
        checks++; if (e !== 1'b1 || lat !== 2) begin errors++; $display("FAIL rdwr20 got err=%b lat=%0d want 1 2", e, lat); end
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, e, q);
        checks++; if (e !== 1'b0 || q !== 32'hCAFE0001) begin errors++; $display("FAIL rd20 got err=%b d=%h want 0 cafe0001", e, q); end
    endtask

    task automatic test_reset_abort();
        int lat; logic e; logic [31:0] q; bit seen;
        access(1'b0, 1'b0, 1'b1, 32'h40, 32'h11112222, lat, e, q);
        @(posedge clk); #1;
        wr2 = 1'b1; adr2 = 32'h40; wd2 = 32'h000055AA;
        @(posedge clk); #1;
        checks++; if (busy2 !== 1'b1 || ready2 !== 1'b0) begin errors++; $display("FAIL abort_wait got b=%b r=%b want 1 0", busy2, ready2); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy2 !== 1'b0 || ready2 !== 1'b0 || rdata2 !== 32'h0) begin errors++; $display("FAIL abort_reset got b=%b r=%b d=%h want 0 0 0", busy2, ready2, rdata2); end
        rst = 1'b1; wr2 = 1'b0;
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (ready2) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_noready got ready_seen=%b want 0", seen); end
        access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, lat, e, q);
        checks++; if (e !== 1'b0 || q !== 32'h11112222) begin errors++; $display("FAIL rd40 got err=%b d=%h want 0 11112222", e, q); end
    endtask

    task automatic test_wait_inputs_ignored();
        int lat; logic e; logic [31:0] q;
        access(1'b0, 1'b0, 1'b1, 32'h84, 32'h84848484, lat, e, q);
        @(posedge clk); #1;
        wr2 = 1'b1; rd2 = 1'b0; adr2 = 32'h80; wd2 = 32'hA5A5A5A5;
        @(posedge clk); #1;
        rd2 = 1'b1; wr2 = 1'b0; adr2 = 32'h84; wd2 = 32'hFFFF0000;
        @(posedge clk); #1;
        checks++; if (ready2 !== 1'b1 || err2 !== 1'b0 || rdata2 !== 32'h11112222) begin errors++; $display("FAIL wait_resp got r=%b e=%b d=%h want 1 0 11112222", ready2, err2, rdata2); end
        rd2 = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, lat, e, q);
        checks++; if (q !== 32'hA5A5A5A5) begin errors++; $display("FAIL rd80 got %h want a5a5a5a5", q); end
        access(1'b0, 1'b1, 1'b0, 32'h84, 32'h0, lat, e, q);
        checks++; if (q !== 32'h84848484) begin errors++; $display("FAIL rd84 got %h want 84848484", q); end
    endtask

    task automatic test_back_to_back();
        int lat; logic e; logic [31:0] q;
        logic [31:0] exp [4];
        exp[0] = 32'h01010101; exp[1] = 32'h02020202; exp[2] = 32'h03030303; exp[3] = 32'h04040404;
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 1'b0, 1'b1, 32'(i * 4), exp[i], lat, e, q);
            checks++; if (lat !== 1 || e !== 1'b0) begin errors++; $display("FAIL l1_wr%0d got lat=%0d err=%b want 1 0", i, lat, e); end
        end
        @(posedge clk); #1;
        rd1 = 1'b1; adr1 = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (ready1 !== 1'b1 || busy1 !== 1'b1 || err1 !== 1'b0 || rdata1 !== exp[i]) begin errors++; $display("FAIL l1_rd%0d got r=%b b=%b e=%b d=%h want 1 1 0 %h", i, ready1, busy1, err1, rdata1, exp[i]); end
            if (i < 3) adr1 = 32'((i + 1) * 4);
            else rd1 = 1'b0;
            @(posedge clk); #1;
            checks++; if (ready1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL l1_idle%0d got r=%b b=%b want 0 0", i, ready1, busy1); end
        end
        access(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, lat, e, q);
        checks++; if (lat !== 1 || e !== 1'b1 || q !== 32'h04040404) begin errors++; $display("FAIL l1_rd400 got lat=%0d err=%b d=%h want 1 1 04040404", lat, e, q); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_misaligned();
        test_conflict();
        test_reset_abort();
        test_wait_inputs_ignored();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
